// File: rtl/inv_sub_bytes_iter.sv
// ============================================================================
//  Module      : inv_sub_bytes_iter
//  Description : Iterative AES InvSubBytes engine. Each byte passes through the
//                inverse affine map and is then inverted in GF(2^8) as x^254
//                by square-and-multiply. LANES bytes are processed per group,
//                and each group takes 8 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_sub_bytes_iter #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int GROUPS = 16 / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    // The top LANES bytes are set; shifting right selects the active group.
    localparam logic [127:0] LANE_MASK = ~({128{1'b1}} >> (LANES * 8));

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
            $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [127:0]   work;
    logic [GW-1:0]  group;
    logic [2:0]     step;
    logic [7:0]     r      [LANES];
    logic [7:0]     x      [LANES];
    logic [7:0]     x_load [LANES];
    logic [7:0]     r_step [LANES];
    logic [7:0]     r_fin  [LANES];
    logic [6:0]     shamt;
    logic [127:0]   work_shift;
    logic [127:0]   fin_packed;
    logic [127:0]   wr_mask;
    logic [127:0]   wr_data;

    // GF(2^8) multiply, reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Inverse of the S-box affine transform.
    function automatic logic [7:0] inv_affine(input logic [7:0] y);
        return {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == LOAD) || (state == COMPUTE);

    // Per-lane arithmetic: group byte selection, load value, iteration step, final square.
    always_comb begin
        shamt      = 7'(int'(group) * LANES * 8);
        work_shift = work << shamt;
        fin_packed = '0;
        for (int l = 0; l < LANES; l++) begin
            x_load[l] = inv_affine(work_shift[127-8*l -: 8]);
            r_step[l] = gf_mul(gf_mul(r[l], r[l]), x[l]);
            r_fin[l]  = gf_mul(r[l], r[l]);
            fin_packed[127-8*l -: 8] = r_fin[l];
        end
        wr_mask = LANE_MASK >> shamt;
        wr_data = fin_packed >> shamt;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = LOAD;
            LOAD:    state_next = COMPUTE;
            COMPUTE: if (step == 3'd7) state_next = (group == GW'(GROUPS - 1)) ? DONE : LOAD;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture input, iterate lanes, write finished group into out_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work      <= '0;
            group     <= '0;
            step      <= '0;
            out_state <= '0;
            for (int l = 0; l < LANES; l++) begin
                r[l] <= 8'h00;
                x[l] <= 8'h00;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= in_state;
                        group <= '0;
                    end
                end
                LOAD: begin
                    for (int l = 0; l < LANES; l++) begin
                        x[l] <= x_load[l];
                        r[l] <= x_load[l];
                    end
                    step <= 3'd1;
                end
                COMPUTE: begin
                    if (step == 3'd7) begin
                        out_state <= (out_state & ~wr_mask) | wr_data;
                        if (group != GW'(GROUPS - 1)) group <= group + GW'(1);
                    end else begin
                        for (int l = 0; l < LANES; l++) r[l] <= r_step[l];
                        step <= step + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
